// File: rtl/spi_master_gen.sv
// Parametrised full-duplex SPI master with a start/busy/done command handshake.
// Mode, SCK divider, chip select and data word are latched when a transfer is accepted.
module spi_master_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int CS_NUM     = 2,
   parameter int DIV_WIDTH  = 8,
   localparam int SEL_W     = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [SEL_W-1:0]      i_cs_sel,
   input  logic                  i_cpol,
   input  logic                  i_cpha,
   input  logic [DIV_WIDTH-1:0]  i_div,
   input  logic                  i_miso,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_sck,
   output logic                  o_mosi,
   output logic [CS_NUM-1:0]     o_cs_n
);

   // state | meaning
   // IDLE  | bus quiet, SCK at latched CPOL, waiting for i_start
   // SETUP | CS asserted, MSB on MOSI, one half-period before first SCK edge
   // XFER  | 2*DATA_WIDTH SCK edges, one per half-period, plus trailing half-period
   // HOLD  | SCK parked at CPOL, CS still asserted for one half-period
   // DONE  | CS released, o_done pulse, o_data updated; may accept next start

   localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  tmr_q, div_q;
   logic [EDGE_W-1:0]     edge_q;
   logic [DATA_WIDTH-1:0] tx_q, rx_q;
   logic                  cpol_q, cpha_q;
   logic [CS_NUM-1:0]     cs_dec_n;

   logic tick, accept, xfer_end, edge_fire, leading, last_edge;

   always_comb begin
      tick      = (tmr_q == '0);
      accept    = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      xfer_end  = (edge_q == EDGE_W'(2 * DATA_WIDTH));
      edge_fire = tick && ((state_q == ST_SETUP) || ((state_q == ST_XFER) && !xfer_end));
      leading   = ~edge_q[0];
      last_edge = (edge_q == EDGE_W'(2 * DATA_WIDTH - 1));
      state_d   = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_SETUP;
         ST_SETUP: if (tick) state_d = ST_XFER;
         ST_XFER:  if (tick && xfer_end) state_d = ST_HOLD;
         ST_HOLD:  if (tick) state_d = ST_DONE;
         ST_DONE:  state_d = accept ? ST_SETUP : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // An out-of-range select matches no index, so the transfer runs with no CS asserted.
   always_comb begin
      cs_dec_n = '1;
      for (int i = 0; i < CS_NUM; i++) begin
         if (i_cs_sel == SEL_W'(i)) cs_dec_n[i] = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cpol_q <= 1'b0;
         cpha_q <= 1'b0;
         div_q  <= '0;
         tmr_q  <= '0;
         edge_q <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         o_data <= '0;
         o_sck  <= 1'b0;
         o_mosi <= 1'b0;
         o_cs_n <= '1;
      end else begin
         o_done <= 1'b0;
         if (accept) begin
            cpol_q <= i_cpol;
            cpha_q <= i_cpha;
            div_q  <= i_div;
            tmr_q  <= i_div;
            edge_q <= '0;
            tx_q   <= i_data;
            rx_q   <= '0;
            o_mosi <= i_data[DATA_WIDTH-1];
            o_sck  <= i_cpol;
            o_cs_n <= cs_dec_n;
            o_busy <= 1'b1;
         end else begin
            if ((state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD)) begin
               if (tick) tmr_q <= div_q;
               else      tmr_q <= tmr_q - DIV_WIDTH'(1);
            end
            if (edge_fire) begin
               o_sck  <= ~o_sck;
               edge_q <= edge_q + EDGE_W'(1);
               if (cpha_q) begin
                  // MSB is re-driven on the first leading edge, then one bit per leading edge.
                  if (leading) begin
                     o_mosi <= tx_q[DATA_WIDTH-1];
                     tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                  end else begin
                     rx_q <= {rx_q[DATA_WIDTH-2:0], i_miso};
                  end
               end else begin
                  if (leading) begin
                     rx_q <= {rx_q[DATA_WIDTH-2:0], i_miso};
                  end else if (!last_edge) begin
                     o_mosi <= tx_q[DATA_WIDTH-2];
                     tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                  end
               end
            end
            if ((state_q == ST_HOLD) && tick) begin
               o_done <= 1'b1;
               o_data <= rx_q;
               o_cs_n <= '1;
               o_busy <= 1'b0;
               o_sck  <= cpol_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: loopback, tied and slave-model MISO in all four modes,
// back-to-back transfers, out-of-range chip select and mid-transfer reset.
module tb_spi_master_gen;
   localparam int DW  = 16;
   localparam int CSN = 3;
   localparam int DVW = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [DW-1:0]  din = '0;
   logic [1:0]     sel = '0;
   logic           cpol = 1'b0;
   logic           cpha = 1'b0;
   logic [DVW-1:0] div = '0;
   logic           miso;
   logic           busy, done, sck, mosi;
   logic [DW-1:0]  dout;
   logic [CSN-1:0] cs_n;

   int   mmode = 0;
   logic miso_s = 1'b0;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   assign miso = (mmode == 0) ? mosi : ((mmode == 1) ? 1'b1 : miso_s);

   always #5 clk = ~clk;

   spi_master_gen #(.DATA_WIDTH(DW), .CS_NUM(CSN), .DIV_WIDTH(DVW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_data(din), .i_cs_sel(sel),
      .i_cpol(cpol), .i_cpha(cpha), .i_div(div), .i_miso(miso),
      .o_busy(busy), .o_done(done), .o_data(dout), .o_sck(sck), .o_mosi(mosi), .o_cs_n(cs_n)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // mm: 0 = MISO looped from MOSI, 1 = MISO tied high, 2 = slave model returning sw
   task automatic do_xfer(input logic [DW-1:0] data, input logic [1:0] s, input logic pol,
                          input logic pha, input logic [DVW-1:0] d, input int mm,
                          input logic [DW-1:0] sw, input bit chain_in, input bit chain_out);
      int h, exp_done, edges, rises, first_edge, last_edge, bad_hp, bad_cs, bad_busy, idx;
      logic [DW-1:0]  cap;
      logic [CSN-1:0] exp_cs;
      logic prev_sck, lead;
      bit   seen;
      exp_t e;
      h        = int'(d) + 1;
      exp_done = 1 + (2 * DW + 2) * h;
      exp_cs   = (s < CSN) ? ~(3'b001 << s) : 3'b111;
      if (!chain_in) @(negedge clk);
      din = data; sel = s; cpol = pol; cpha = pha; div = d; mmode = mm; start = 1'b1;
      idx    = pha ? 0 : 1;
      miso_s = pha ? 1'b0 : sw[DW-1];
      e.data = (mm == 0) ? data : ((mm == 1) ? 16'hFFFF : sw);
      e.cyc  = exp_done;
      sb.push_back(e);
      @(posedge clk);
      edges = 0; rises = 0; first_edge = 0; last_edge = 0;
      bad_hp = 0; bad_cs = 0; bad_busy = 0; cap = '0;
      prev_sck = pol; seen = 1'b0;
      for (int c = 1; (c <= exp_done + 8) && !seen; c++) begin
         @(negedge clk);
         if (c == 1) start = chain_out;
         if (c == 3) begin
            din = ~data; sel = ~s; cpol = ~pol; cpha = ~pha; div = d + 8'd3;
         end
         if (done) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", c, e.cyc);
               chk("rx_data", dout, e.data);
            end
            chk("cs_at_done", cs_n, 3'b111);
            chk("busy_at_done", busy, 1'b0);
         end else begin
            if (cs_n !== exp_cs) bad_cs++;
            if (busy !== 1'b1) bad_busy++;
            if (sck !== prev_sck) begin
               edges++;
               if (sck) rises++;
               if (edges == 1) first_edge = c;
               else if (c - last_edge != h) bad_hp++;
               last_edge = c;
               lead = (sck != pol);
               if (pha ? !lead : lead) cap = {cap[DW-2:0], mosi};
               if ((pha ? lead : !lead) && idx < DW) begin
                  miso_s = sw[DW-1-idx];
                  idx++;
               end
               prev_sck = sck;
            end
         end
      end
      chk("done_seen", seen, 1'b1);
      chk("edge_count", edges, 2 * DW);
      chk("rise_count", rises, DW);
      chk("first_edge_cycle", first_edge, 1 + h);
      chk("half_period_bad", bad_hp, 0);
      chk("mosi_bits", cap, data);
      chk("cs_bad_cycles", bad_cs, 0);
      chk("busy_bad_cycles", bad_busy, 0);
   endtask

   initial begin
      int bad_done;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_data", dout, 16'h0000);
      chk("rst_sck", sck, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_cs", cs_n, 3'b111);
      rst_n = 1'b1;

      // mode 0, loopback
      do_xfer(16'hA55A, 2'd0, 1'b0, 1'b0, 8'd1, 0, 16'h0000, 1'b0, 1'b0);
      // mode 3, MISO tied high, fastest SCK
      do_xfer(16'h8001, 2'd0, 1'b1, 1'b1, 8'd0, 1, 16'h0000, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("sck_idle_cpol1", sck, 1'b1);
      chk("cs_idle", cs_n, 3'b111);
      // modes 1 and 2 against a slave model
      do_xfer(16'h0F35, 2'd2, 1'b0, 1'b1, 8'd3, 2, 16'h1234, 1'b0, 1'b0);
      do_xfer(16'hC3A6, 2'd1, 1'b1, 1'b0, 8'd3, 2, 16'h1234, 1'b0, 1'b0);
      // start held high: back-to-back on CS1, second start during busy ignored
      do_xfer(16'h3C5A, 2'd1, 1'b0, 1'b0, 8'd1, 0, 16'h0000, 1'b0, 1'b1);
      do_xfer(16'hF00F, 2'd1, 1'b0, 1'b0, 8'd1, 0, 16'h0000, 1'b1, 1'b0);
      // out-of-range chip select
      do_xfer(16'h0F0F, 2'd3, 1'b0, 1'b0, 8'd2, 0, 16'h0000, 1'b0, 1'b0);

      // reset in the middle of a mode 3 transfer
      @(negedge clk);
      din = 16'hFFFF; sel = 2'd0; cpol = 1'b1; cpha = 1'b1; div = 8'd1; mmode = 0; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
      end
      chk("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_data", dout, 16'h0000);
      chk("mid_rst_sck", sck, 1'b0);
      chk("mid_rst_mosi", mosi, 1'b0);
      chk("mid_rst_cs", cs_n, 3'b111);
      bad_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) bad_done++;
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0) bad_done++;
      end
      chk("no_done_after_rst", bad_done, 0);
      do_xfer(16'h6B29, 2'd0, 1'b0, 1'b0, 8'd1, 0, 16'h0000, 1'b0, 1'b0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no end of run expected finish before 2 ms");
      $fatal(1, "timeout");
   end
endmodule
